mem_req_ctrl: RTL and testbench

Request-side controller sitting directly upstream of the `memory` block. Accepts read/write requests on a valid/ready stream, buffers them in a small in-order FIFO, sequences them onto the memory's single `addr`/`wr_en`/`rd_en`/`wdata` port, and returns read data on a valid/ready response stream. It lets test stimulus or a bus front-end issue back-to-back requests without tracking memory timing.

---
 rtl/mem_req_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_req_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// Request-side controller for the memory block: buffers read/write requests
// in an in-order FIFO and sequences them onto the single memory port.
module mem_req_ctrl #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               req_valid,
   output logic                               req_ready,
   input  logic                               req_wr,
   input  logic [ADDR_WIDTH-1:0]              req_addr,
   input  logic [DATA_WIDTH-1:0]              req_wdata,
   output logic                               rsp_valid,
   input  logic                               rsp_ready,
   output logic [DATA_WIDTH-1:0]              rsp_rdata,
   output logic [ADDR_WIDTH-1:0]              mem_addr,
   output logic                               mem_wr_en,
   output logic                               mem_rd_en,
   output logic [DATA_WIDTH-1:0]              mem_wdata,
   input  logic [DATA_WIDTH-1:0]              mem_rdata,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      CAPT,
      RESP
   } state_t;

   state_t                 state;
   logic [PW-1:0]          wptr;
   logic [PW-1:0]          rptr;
   logic                   push;
   logic                   pop;

   logic                   fifo_wr   [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0]  fifo_addr [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]  fifo_data [FIFO_DEPTH];

   assign req_ready = (fifo_count != CW'(FIFO_DEPTH));
   assign push      = req_valid && req_ready;
   assign pop       = (state == IDLE) && (fifo_count != '0);

   // Entry storage needs no reset; pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_wr[wptr]   <= req_wr;
         fifo_addr[wptr] <= req_addr;
         fifo_data[wptr] <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr       <= '0;
         rptr       <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + PW'(1);
         end
         if (pop) begin
            rptr <= rptr + PW'(1);
         end
         unique case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Issue FSM: one memory operation in flight, strobes last one cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wr_en <= 1'b0;
         mem_rd_en <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pop) begin
                  mem_addr  <= fifo_addr[rptr];
                  mem_wdata <= fifo_data[rptr];
                  if (fifo_wr[rptr]) begin
                     mem_wr_en <= 1'b1;
                     state     <= WRITE;
                  end else begin
                     mem_rd_en <= 1'b1;
                     state     <= READ;
                  end
               end
            end
            WRITE: begin
               mem_wr_en <= 1'b0;
               state     <= IDLE;
            end
            READ: begin
               mem_rd_en <= 1'b0;
               state     <= CAPT;
            end
            CAPT: begin
               rsp_rdata <= mem_rdata;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               mem_wr_en <= 1'b0;
               mem_rd_en <= 1'b0;
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl with a behavioural memory and
// a reference model that tracks memory contents at request time.
module tb_mem_req_ctrl;

   logic       clk;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic       req_wr;
   logic [1:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_rdata;
   logic [1:0] mem_addr;
   logic       mem_wr_en;
   logic       mem_rd_en;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic [2:0] fifo_count;

   mem_req_ctrl #(
      .ADDR_WIDTH(2),
      .DATA_WIDTH(8),
      .FIFO_DEPTH(4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wr     (req_wr),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .mem_addr   (mem_addr),
      .mem_wr_en  (mem_wr_en),
      .mem_rd_en  (mem_rd_en),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .fifo_count (fifo_count)
   );

   // Memory with one-cycle registered read.
   logic [7:0] mem_arr [4];
   always @(posedge clk) begin
      if (mem_wr_en) mem_arr[mem_addr] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= mem_arr[mem_addr];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic       wr;
      logic [1:0] addr;
      logic [7:0] data;
   } op_t;

   op_t        op_q [$];
   logic [7:0] rsp_q [$];
   logic [7:0] rsp_log [$];
   logic [7:0] ref_mem [4];

   int  checks = 0;
   int  errors = 0;
   int  rd_cnt = 0;
   int  rsp_cnt = 0;
   int  last_rd_cyc = 0;
   int  last_wr_cyc = 0;
   int  last_rise_cyc = 0;
   bit  rnd_mode = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Monitor: pops expected memory ops and responses as the DUT shows them.
   logic       prev_hold = 0;
   logic       prev_valid = 0;
   logic [7:0] prev_data = 0;
   always @(negedge clk) begin
      if (!reset) begin
         prev_hold  = 0;
         prev_valid = 0;
      end else begin
         chk("strobe_excl", 32'(mem_wr_en && mem_rd_en), 0);
         if (mem_wr_en || mem_rd_en) begin
            op_t op;
            if (mem_rd_en) begin
               rd_cnt++;
               last_rd_cyc = cyc;
            end
            if (mem_wr_en) last_wr_cyc = cyc;
            chk("strobe_expected", 32'(op_q.size() != 0), 1);
            if (op_q.size() != 0) begin
               op = op_q.pop_front();
               chk("op_kind", 32'(mem_wr_en), 32'(op.wr));
               chk("op_addr", 32'(mem_addr), 32'(op.addr));
               if (op.wr) chk("op_wdata", 32'(mem_wdata), 32'(op.data));
            end
         end
         if (prev_hold) begin
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_data", 32'(rsp_rdata), 32'(prev_data));
         end
         if (rsp_valid && !prev_valid) last_rise_cyc = cyc;
         if (rsp_valid && rsp_ready) begin
            rsp_cnt++;
            rsp_log.push_back(rsp_rdata);
            chk("rsp_expected", 32'(rsp_q.size() != 0), 1);
            if (rsp_q.size() != 0) chk("rsp_data", 32'(rsp_rdata), 32'(rsp_q.pop_front()));
         end
         prev_hold  = rsp_valid && !rsp_ready;
         prev_valid = rsp_valid;
         prev_data  = rsp_rdata;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_mode) rsp_ready = ($urandom_range(0, 3) != 0);
   endtask

   // Reference model: in-order execution means memory state at push time
   // decides what a read returns.
   task automatic send(input logic wr, input logic [1:0] a,
                       input logic [7:0] d, input int tmo,
                       output bit acc, output int acyc);
      req_valid = 1;
      req_wr    = wr;
      req_addr  = a;
      req_wdata = d;
      acc  = 0;
      acyc = 0;
      for (int i = 0; i < tmo && !acc; i++) begin
         @(negedge clk);
         if (req_ready && reset) begin
            acc  = 1;
            acyc = cyc;
            op_q.push_back(op_t'({wr, a, d}));
            if (wr) ref_mem[a] = d;
            else    rsp_q.push_back(ref_mem[a]);
         end
         tick();
      end
      req_valid = 0;
   endtask

   task automatic put(input logic wr, input logic [1:0] a,
                      input logic [7:0] d, output int acyc);
      bit acc;
      send(wr, a, d, 200, acc, acyc);
      chk("req_accept", 32'(acc), 1);
   endtask

   task automatic drain();
      int n = 0;
      while ((op_q.size() != 0 || rsp_q.size() != 0 || rsp_valid ||
              fifo_count != 0) && n < 1000) begin
         tick();
         n++;
      end
      chk("drain_done", 32'(n < 1000), 1);
   endtask

   initial begin
      int  c;
      int  base;
      int  nacc;
      bit  acc;
      reset     = 0;
      req_valid = 1;
      req_wr    = 1;
      req_addr  = 2'd1;
      req_wdata = 8'hFF;
      rsp_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 32'(fifo_count), 0);
      chk("rst_wr_en", 32'(mem_wr_en), 0);
      chk("rst_rd_en", 32'(mem_rd_en), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_wdata", 32'(mem_wdata), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
      req_valid = 0;
      reset     = 1;
      chk("rst_req_ready", 32'(req_ready), 1);
      tick();
      chk("rst_no_push", 32'(fifo_count), 0);

      // Round trip with latency measured from the push edge.
      rsp_ready = 1;
      put(1, 2'd2, 8'hA5, c);
      drain();
      chk("wr_latency", 32'(last_wr_cyc - c), 2);
      rsp_log.delete();
      put(0, 2'd2, 8'h00, c);
      drain();
      chk("rd_latency", 32'(last_rd_cyc - c), 2);
      chk("rsp_latency", 32'(last_rise_cyc - c), 4);
      chk("rt_data", 32'(rsp_log.size() == 1 ? rsp_log[0] : 8'h00), 32'hA5);

      // Backpressure hold.
      put(1, 2'd1, 8'h3C, c);
      drain();
      rsp_ready = 0;
      put(0, 2'd1, 8'h00, c);
      for (int n = 0; n < 20 && !rsp_valid; n++) tick();
      chk("bp_wait", 32'(rsp_valid), 1);
      base = rsp_cnt;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(rsp_valid), 1);
         chk("bp_data", 32'(rsp_rdata), 32'h3C);
         tick();
      end
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
      repeat (2) tick();
      chk("bp_one_rsp", 32'(rsp_cnt - base), 1);
      rsp_ready = 1;
      drain();

      // Ordering and pointer wrap, back-to-back.
      rsp_log.delete();
      put(1, 2'd0, 8'h11, c);
      put(1, 2'd1, 8'h22, c);
      put(1, 2'd2, 8'h33, c);
      put(1, 2'd3, 8'h44, c);
      put(0, 2'd3, 8'h00, c);
      put(0, 2'd0, 8'h00, c);
      put(0, 2'd1, 8'h00, c);
      put(0, 2'd2, 8'h00, c);
      drain();
      chk("ord_count", 32'(rsp_log.size()), 4);
      if (rsp_log.size() == 4) begin
         chk("ord_0", 32'(rsp_log[0]), 32'h44);
         chk("ord_1", 32'(rsp_log[1]), 32'h11);
         chk("ord_2", 32'(rsp_log[2]), 32'h22);
         chk("ord_3", 32'(rsp_log[3]), 32'h33);
      end

      // Full FIFO with a stalled response.
      rsp_ready = 0;
      base = rd_cnt;
      nacc = 0;
      for (int i = 0; i < 6; i++) begin
         send(0, 2'(i), 8'h00, 4, acc, c);
         if (acc) nacc++;
      end
      chk("full_accepted", 32'(nacc), 5);
      chk("full_count", 32'(fifo_count), 4);
      chk("full_ready", 32'(req_ready), 0);
      repeat (3) tick();
      chk("full_one_rd", 32'(rd_cnt - base), 1);
      rsp_ready = 1;
      drain();

      // Reset while the first of three reads is in CAPT.
      put(0, 2'd0, 8'h00, c);
      put(0, 2'd1, 8'h00, c);
      put(0, 2'd2, 8'h00, c);
      chk("mid_in_capt", 32'(cyc - last_rd_cyc), 1);
      chk("mid_queued", 32'(fifo_count), 2);
      reset = 0;
      op_q.delete();
      rsp_q.delete();
      base = rsp_cnt;
      tick();
      reset = 1;
      chk("mid_count", 32'(fifo_count), 0);
      chk("mid_rsp_valid", 32'(rsp_valid), 0);
      chk("mid_rd_en", 32'(mem_rd_en), 0);
      repeat (10) tick();
      chk("mid_no_rsp", 32'(rsp_cnt - base), 0);
      chk("mid_count_idle", 32'(fifo_count), 0);

      // Randomized traffic with random response backpressure.
      rnd_mode = 1;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) tick();
         put(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             8'($urandom_range(0, 255)), c);
      end
      drain();
      rnd_mode  = 0;
      rsp_ready = 1;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
